multi_mode_game_counter: RTL and testbench

Parametrised successor of the 4-bit multi-mode up/down game counter. It holds a wrapping counter in `[0, MAX_VALUE]` with four step modes, a load path and a synchronous clear, and keeps win/loss tallies. A two-state FSM declares game over when either tally reaches `WIN_ROUNDS`. It sits in the counter subsystem behind the same control interface and adds an enable, a configurable large step, wrap-safe arithmetic, single-counted scoring events and a sticky game-over.

---
 rtl/mmc_pkg.sv | 20 ++
 rtl/mmc_tally.sv | 38 +++
 rtl/multi_mode_game_counter.sv | 137 +++++++++++++
 tb/tb_multi_mode_game_counter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc_pkg.sv
// Shared types and constants for the multi-mode game counter.
package mmc_pkg;

    typedef enum logic [1:0] {
        UP1 = 2'b00,
        UPN = 2'b01,
        DN1 = 2'b10,
        DNN = 2'b11
    } mode_e;

    typedef enum logic {
        RUN  = 1'b0,
        OVER = 1'b1
    } state_e;

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_LOSE = 2'b01;
    localparam logic [1:0] WHO_WIN  = 2'b10;

endpackage

// File: rtl/mmc_tally.sv
// Saturating round tally; done_c flags the update that lands on WIN_ROUNDS.
module mmc_tally #(
    parameter int unsigned WIN_ROUNDS = 15,
    parameter int unsigned TW         = $clog2(WIN_ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [TW-1:0] cnt_o,
    output logic          done_c
);

    localparam logic [TW-1:0] TOP = TW'(WIN_ROUNDS);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != TOP)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_c = (cnt_d == TOP) && (cnt_q != TOP);

endmodule

// File: rtl/multi_mode_game_counter.sv
// Wrapping multi-mode counter with win/loss tallies and a sticky game-over FSM.
module multi_mode_game_counter
    import mmc_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MAX_VALUE  = 2**WIDTH - 1,
    parameter int unsigned STEP_LARGE = 2,
    parameter int unsigned WIN_ROUNDS = 15,
    parameter int unsigned TW         = $clog2(WIN_ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] count,
    output logic [TW-1:0]    win_cnt,
    output logic [TW-1:0]    lose_cnt,
    output logic             win_evt,
    output logic             lose_evt,
    output logic             gameover,
    output logic [1:0]       who
);

    localparam int unsigned    XW      = WIDTH + 1;
    localparam logic [XW-1:0]  RANGE_X = XW'(MAX_VALUE + 1);
    localparam logic [XW-1:0]  MAX_X   = XW'(MAX_VALUE);
    localparam logic [XW-1:0]  STEP_X  = XW'(STEP_LARGE);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);

    if ((MAX_VALUE < 1) || (MAX_VALUE > 2**WIDTH - 1)) begin : g_bad_max
        $error("MAX_VALUE must lie in [1, 2**WIDTH-1]");
    end
    if ((STEP_LARGE < 1) || (STEP_LARGE > MAX_VALUE)) begin : g_bad_step
        $error("STEP_LARGE must lie in [1, MAX_VALUE]");
    end
    if (WIN_ROUNDS < 1) begin : g_bad_rounds
        $error("WIN_ROUNDS must be at least 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [1:0]       who_q, who_d;
    logic             win_evt_q, win_evt_d;
    logic             lose_evt_q, lose_evt_d;

    mode_e         mode;
    logic [XW-1:0] cnt_x, step_x, up_sum, dn_sum, up_x, dn_x, next_x;
    logic          is_up, step_ok, win_score, lose_score;
    logic          win_done_c, lose_done_c;

    assign mode = mode_e'(control);

    // Wrap-safe step: sums stay below 2**(WIDTH+1), then fold once into [0, MAX_VALUE].
    always_comb begin
        cnt_x      = {1'b0, count_q};
        step_x     = ((mode == UPN) || (mode == DNN)) ? STEP_X : XW'(1);
        up_sum     = cnt_x + step_x;
        dn_sum     = cnt_x + RANGE_X - step_x;
        up_x       = (up_sum >= RANGE_X) ? (up_sum - RANGE_X) : up_sum;
        dn_x       = (dn_sum >= RANGE_X) ? (dn_sum - RANGE_X) : dn_sum;
        is_up      = (mode == UP1) || (mode == UPN);
        next_x     = is_up ? up_x : dn_x;
        step_ok    = (state_q == RUN) && !clear && !load && enable;
        win_score  = step_ok && is_up && (next_x == MAX_X) && (cnt_x != MAX_X);
        lose_score = step_ok && !is_up && (next_x == '0) && (cnt_x != '0);
    end

    mmc_tally #(.WIN_ROUNDS(WIN_ROUNDS), .TW(TW)) u_win_tally (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clear),
        .inc_i  (win_score),
        .cnt_o  (win_cnt),
        .done_c (win_done_c)
    );

    mmc_tally #(.WIN_ROUNDS(WIN_ROUNDS), .TW(TW)) u_lose_tally (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clear),
        .inc_i  (lose_score),
        .cnt_o  (lose_cnt),
        .done_c (lose_done_c)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        who_d      = who_q;
        win_evt_d  = 1'b0;
        lose_evt_d = 1'b0;
        if (clear) begin
            state_d = RUN;
            count_d = '0;
            who_d   = WHO_NONE;
        end else if (state_q == RUN) begin
            if (load) begin
                count_d = (load_value > MAX_W) ? MAX_W : load_value;
            end else if (enable) begin
                count_d = next_x[WIDTH-1:0];
            end
            win_evt_d  = win_score;
            lose_evt_d = lose_score;
            if (win_done_c || lose_done_c) begin
                state_d = OVER;
                count_d = '0;
                who_d   = win_done_c ? WHO_WIN : WHO_LOSE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            count_q    <= '0;
            who_q      <= WHO_NONE;
            win_evt_q  <= 1'b0;
            lose_evt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            who_q      <= who_d;
            win_evt_q  <= win_evt_d;
            lose_evt_q <= lose_evt_d;
        end
    end

    assign count    = count_q;
    assign who      = who_q;
    assign win_evt  = win_evt_q;
    assign lose_evt = lose_evt_q;
    assign gameover = (state_q == OVER);

endmodule

// File: tb/tb_multi_mode_game_counter.sv
// Bench for two counter configurations sharing one stimulus stream.
module tb_multi_mode_game_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [4:0] lv = '0;
    logic [1:0] control = 2'b00;

    // Config A: defaults (WIDTH 4, MAX 15, STEP 2, WIN_ROUNDS 15)
    logic [3:0] a_count, a_win, a_lose;
    logic       a_wevt, a_levt, a_go;
    logic [1:0] a_who;
    // Config B: WIDTH 5, MAX 15, STEP 3, WIN_ROUNDS 2
    logic [4:0] b_count;
    logic [1:0] b_win, b_lose;
    logic       b_wevt, b_levt, b_go;
    logic [1:0] b_who;

    int tests = 0;
    int fails = 0;

    localparam int C_MAX = 15;

    always #5 clk = ~clk;

    multi_mode_game_counter dut_a (
        .clk(clk), .rst(rst), .clear(clear), .enable(enable), .load(load),
        .load_value(lv[3:0]), .control(control),
        .count(a_count), .win_cnt(a_win), .lose_cnt(a_lose),
        .win_evt(a_wevt), .lose_evt(a_levt), .gameover(a_go), .who(a_who)
    );

    multi_mode_game_counter #(
        .WIDTH(5), .MAX_VALUE(15), .STEP_LARGE(3), .WIN_ROUNDS(2)
    ) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .enable(enable), .load(load),
        .load_value(lv), .control(control),
        .count(b_count), .win_cnt(b_win), .lose_cnt(b_lose),
        .win_evt(b_wevt), .lose_evt(b_levt), .gameover(b_go), .who(b_who)
    );

    // Reference model: game rules in plain integer arithmetic, one slot per config.
    int m_cnt[2], m_win[2], m_lose[2], m_who[2];
    bit m_wevt[2], m_levt[2], m_over[2];

    function automatic int c_step(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int c_wr(input int i);
        return (i == 0) ? 15 : 2;
    endfunction

    task automatic model_edge(input int i);
        int lv_i, s, nxt;
        bit up, w, l;
        lv_i = (i == 0) ? int'(lv[3:0]) : int'(lv);
        w = 1'b0;
        l = 1'b0;
        if (rst || clear) begin
            m_cnt[i] = 0; m_win[i] = 0; m_lose[i] = 0; m_who[i] = 0; m_over[i] = 1'b0;
        end else if (!m_over[i]) begin
            if (load) begin
                m_cnt[i] = (lv_i > C_MAX) ? C_MAX : lv_i;
            end else if (enable) begin
                s   = control[0] ? c_step(i) : 1;
                up  = !control[1];
                nxt = up ? (m_cnt[i] + s) % (C_MAX + 1) : (m_cnt[i] - s + C_MAX + 1) % (C_MAX + 1);
                w   = up && (nxt == C_MAX) && (m_cnt[i] != C_MAX);
                l   = !up && (nxt == 0) && (m_cnt[i] != 0);
                m_cnt[i] = nxt;
                if (w) m_win[i]++;
                if (l) m_lose[i]++;
                if ((w && m_win[i] == c_wr(i)) || (l && m_lose[i] == c_wr(i))) begin
                    m_over[i] = 1'b1;
                    m_cnt[i]  = 0;
                    m_who[i]  = w ? 2 : 1;
                end
            end
        end
        m_wevt[i] = w;
        m_levt[i] = l;
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; clear = 1'b0; enable = 1'b0; load = 1'b0; control = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({a_count, a_win, a_lose, a_wevt, a_levt, a_go, a_who} !== 17'd0) begin
            fails++;
            $display("FAIL reset_a got %h exp 0", {a_count, a_win, a_lose, a_wevt, a_levt, a_go, a_who});
        end
        tests++;
        if ({b_count, b_win, b_lose, b_wevt, b_levt, b_go, b_who} !== 14'd0) begin
            fails++;
            $display("FAIL reset_b got %h exp 0", {b_count, b_win, b_lose, b_wevt, b_levt, b_go, b_who});
        end
    endtask

    task automatic test_count_up();
        idle();
        enable = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            tests++;
            if (a_count !== 4'(k)) begin
                fails++;
                $display("FAIL up_count step %0d got %0d exp %0d", k, a_count, k);
            end
            tests++;
            if (a_wevt !== (k == 15)) begin
                fails++;
                $display("FAIL up_win_evt step %0d got %0b exp %0b", k, a_wevt, (k == 15));
            end
        end
        tests++;
        if (a_win !== 4'd1) begin
            fails++;
            $display("FAIL up_win_cnt got %0d exp 1", a_win);
        end
        enable = 1'b0;
        tick();
        tests++;
        if ({a_wevt, a_count} !== {1'b0, 4'd15}) begin
            fails++;
            $display("FAIL up_evt_pulse got %h exp 0f", {a_wevt, a_count});
        end
    endtask

    task automatic test_load_wrap();
        idle();
        load = 1'b1; lv = 5'd14;
        tick();
        load = 1'b0; enable = 1'b1; control = 2'b01;
        tick();
        tests++;
        if ({a_count, a_wevt, a_win} !== {4'd0, 1'b0, 4'd1}) begin
            fails++;
            $display("FAIL wrap_no_score got %h exp %h", {a_count, a_wevt, a_win}, {4'd0, 1'b0, 4'd1});
        end
        control = 2'b00;
        tick();
        control = 2'b10;
        tick();
        tests++;
        if ({a_count, a_lose, a_levt} !== {4'd0, 4'd1, 1'b1}) begin
            fails++;
            $display("FAIL down_loss got %h exp %h", {a_count, a_lose, a_levt}, {4'd0, 4'd1, 1'b1});
        end
    endtask

    task automatic test_clamp();
        idle();
        load = 1'b1; lv = 5'd20;
        tick();
        tests++;
        if ({b_count, b_wevt} !== {5'd15, 1'b0}) begin
            fails++;
            $display("FAIL clamp_load got %h exp %h", {b_count, b_wevt}, {5'd15, 1'b0});
        end
        load = 1'b0; enable = 1'b1; control = 2'b00;
        tick();
        tests++;
        if ({b_count, b_wevt} !== {5'd0, 1'b0}) begin
            fails++;
            $display("FAIL clamp_wrap got %h exp %h", {b_count, b_wevt}, {5'd0, 1'b0});
        end
    endtask

    task automatic test_gameover();
        idle();
        rst = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            idle(); load = 1'b1; lv = 5'd14;
            tick();
            idle(); enable = 1'b1;
            tick();
        end
        tests++;
        if ({b_go, b_who, b_count, b_win, b_wevt} !== {1'b1, 2'b10, 5'd0, 2'd2, 1'b1}) begin
            fails++;
            $display("FAIL over_entry got %h exp %h", {b_go, b_who, b_count, b_win, b_wevt},
                     {1'b1, 2'b10, 5'd0, 2'd2, 1'b1});
        end
        for (int k = 0; k < 10; k++) begin
            enable = 1'b1; control = 2'($urandom); load = ($urandom_range(3) == 0); lv = 5'd14;
            tick();
        end
        tests++;
        if ({b_go, b_who, b_count, b_win, b_lose, b_wevt, b_levt} !== {1'b1, 2'b10, 5'd0, 2'd2, 2'd0, 2'b00}) begin
            fails++;
            $display("FAIL over_frozen got %h exp %h", {b_go, b_who, b_count, b_win, b_lose, b_wevt, b_levt},
                     {1'b1, 2'b10, 5'd0, 2'd2, 2'd0, 2'b00});
        end
        idle(); clear = 1'b1;
        tick();
        tests++;
        if ({b_count, b_win, b_lose, b_wevt, b_levt, b_go, b_who} !== 14'd0) begin
            fails++;
            $display("FAIL over_clear got %h exp 0", {b_count, b_win, b_lose, b_wevt, b_levt, b_go, b_who});
        end
        idle(); enable = 1'b1;
        tick();
        tests++;
        if (b_count !== 5'd1) begin
            fails++;
            $display("FAIL run_after_clear got %0d exp 1", b_count);
        end
    endtask

    task automatic test_clear_priority();
        idle(); load = 1'b1; lv = 5'd5;
        tick();
        clear = 1'b1; load = 1'b1; enable = 1'b1; lv = 5'd7;
        tick();
        tests++;
        if ({a_count, b_count} !== 9'd0) begin
            fails++;
            $display("FAIL clear_vs_load got %h exp 0", {a_count, b_count});
        end
    endtask

    task automatic test_rst_cases();
        for (int r = 0; r < 2; r++) begin
            idle(); load = 1'b1; lv = 5'd14;
            tick();
            idle(); enable = 1'b1;
            tick();
        end
        tests++;
        if (b_go !== 1'b1) begin
            fails++;
            $display("FAIL rst_setup_over got %0b exp 1", b_go);
        end
        idle(); rst = 1'b1; enable = 1'b1;
        tick();
        tests++;
        if ({b_count, b_win, b_lose, b_wevt, b_levt, b_go, b_who} !== 14'd0) begin
            fails++;
            $display("FAIL rst_in_over got %h exp 0", {b_count, b_win, b_lose, b_wevt, b_levt, b_go, b_who});
        end
        idle(); load = 1'b1; lv = 5'd14;
        tick();
        idle(); enable = 1'b1;
        tick();
        idle(); load = 1'b1; lv = 5'd9;
        tick();
        tests++;
        if ({a_count, a_win} !== {4'd9, 4'd1}) begin
            fails++;
            $display("FAIL rst_setup_mid got %h exp %h", {a_count, a_win}, {4'd9, 4'd1});
        end
        idle(); rst = 1'b1; enable = 1'b1;
        tick();
        tests++;
        if ({a_count, a_win, a_lose, a_wevt, a_levt, a_go, a_who} !== 17'd0) begin
            fails++;
            $display("FAIL rst_mid got %h exp 0", {a_count, a_win, a_lose, a_wevt, a_levt, a_go, a_who});
        end
    endtask

    task automatic test_random();
        logic [16:0] exp_a;
        logic [13:0] exp_b;
        idle(); rst = 1'b1;
        tick();
        for (int k = 0; k < 1500; k++) begin
            rst     = ($urandom_range(255) == 0);
            clear   = ($urandom_range(127) == 0);
            load    = ($urandom_range(7) == 0);
            enable  = ($urandom_range(3) != 0);
            control = 2'($urandom);
            lv      = ($urandom_range(1) == 1) ? 5'(12 + $urandom_range(0, 6)) : 5'($urandom);
            tick();
            exp_a = {4'(m_cnt[0]), 4'(m_win[0]), 4'(m_lose[0]), m_wevt[0], m_levt[0], m_over[0], 2'(m_who[0])};
            exp_b = {5'(m_cnt[1]), 2'(m_win[1]), 2'(m_lose[1]), m_wevt[1], m_levt[1], m_over[1], 2'(m_who[1])};
            tests++;
            if ({a_count, a_win, a_lose, a_wevt, a_levt, a_go, a_who} !== exp_a) begin
                fails++;
                $display("FAIL rand_a cycle %0d got %h exp %h", k,
                         {a_count, a_win, a_lose, a_wevt, a_levt, a_go, a_who}, exp_a);
            end
            tests++;
            if ({b_count, b_win, b_lose, b_wevt, b_levt, b_go, b_who} !== exp_b) begin
                fails++;
                $display("FAIL rand_b cycle %0d got %h exp %h", k,
                         {b_count, b_win, b_lose, b_wevt, b_levt, b_go, b_who}, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_wrap();
        test_clamp();
        test_gameover();
        test_clear_priority();
        test_rst_cases();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
